dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Handshaked, multi-cycle data-memory responder: the slave end of the load/store interface driven by the pipelined core's MEM stage.
- Accepts one read or write request at a time and inserts a programmable number of wait states.
- Performs a word access with byte-enable merge on writes, then holds a response until the initiator takes it.
- Replaces the single-cycle data memory so the core's stall/handshake logic can be exercised.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
- WAIT_CYCLES, 2, wait states between request accept and memory access; range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i]; used on stores only.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for store responses.
- rsp_err  out  1  error response; constant 0 unless DMEM_ERR_EN is defined.

Behaviour:
- Reset, with rst low at a rising edge:
  - State goes to IDLE; wait counter = 0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is not reset.
- Reset mid-operation: the pending request is dropped. A store whose commit edge has not yet occurred never writes memory.
- States: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
  - rsp_valid=1 only in RESP.
- Accept: edge E where the state is IDLE and req_valid=1.
  - Latch write, addr, wdata and be.
  - If WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES.
  - If WAIT_CYCLES=0: perform the access at E and go to RESP.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter equals 1: perform the access, load rsp_rdata/rsp_err, go to RESP.
  - Net timing: the access edge is E+WAIT_CYCLES, and rsp_valid is visible in the cycle after that edge.
- Access:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Without DMEM_ERR_EN: upper address bits are ignored (wrap) and addr[1:0] is ignored.
  - Load: rsp_rdata = mem[index] (registered).
  - Store: each byte with be[i]=1 is replaced; other bytes are kept. be=4'b0000 leaves memory unchanged and still returns a response. rsp_rdata=0.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err stay stable until an edge with rsp_ready=1, then go to IDLE.
  - rsp_valid drops in IDLE; rsp_rdata keeps its last value.
- Throughput:
  - One transaction per WAIT_CYCLES+2 cycles minimum.
  - A new request is never accepted in the same cycle a response retires.
  - req_valid/req_* are ignored outside IDLE.
- Read-after-write: a load following a store to the same index returns the merged word.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined — error response when either condition holds:
  - addr[1:0]!=0 (misaligned), or
  - addr[31:log2(DEPTH_WORDS)+2]!=0 (out of range).
- On error: no memory read or write, rsp_err=1, rsp_rdata=0, same latency and handshake as a normal access.
- Otherwise rsp_err=0.
- Not defined: no checks, wrap/ignore rules as in Behaviour, rsp_err tied 0.

Test Plan:
- Reset, then store then load (WAIT_CYCLES=2):
  - rst low 2 edges -> req_ready=1, rsp_valid=0, rsp_rdata=0.
  - Store addr 0x10, wdata 0xDEADBEEF, be=4'hF accepted at edge E -> rsp_valid from cycle after E+2, rsp_rdata=0.
  - Load 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte merge:
  - Word 0x20 holds 0x11223344; store wdata 0xAABBCCDD, be=4'b0101 -> load 0x20 returns 0x11BB33DD.
  - A following store with be=0 -> unchanged.
- Response backpressure:
  - Load response with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable.
  - req_ready=0 throughout; a req_valid pulse during that time is ignored (no second response).
  - rsp_ready=1 -> IDLE next cycle.
- WAIT_CYCLES=0 instance: back-to-back load requests -> each response 1 cycle after accept; accepts spaced 2 cycles minimum.
- Reset mid-operation:
  - Store 0x30, wdata 0x12345678, accepted; assert rst during WAIT -> IDLE, no response.
  - Load 0x30 returns the prior contents.
- Addressing per build (DEPTH_WORDS=256):
  - DMEM_ERR_EN defined: load 0x00000402 -> rsp_err=1, rsp_rdata=0; store to 0x00000400 -> rsp_err=1, memory unchanged.
  - DMEM_ERR_EN undefined: store 0x00000400 aliases word 0 -> load 0x0 returns the stored value, rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data-memory slave for the core's MEM stage.
// Accepts one load/store at a time, waits WAIT_CYCLES edges, performs a word
// access (byte-enable merge on stores), then holds the response until taken.
// Optional build macro DMEM_ERR_EN: misaligned or out-of-range addresses return
// an error response instead of touching memory.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   req_t            lat, acc;
   logic            accept, do_access, acc_err;
   logic [AW-1:0]   acc_idx;
   logic [31:0]     mem [DEPTH_WORDS];

   // With zero wait states the access happens on the accept edge, so the
   // access operands come straight from the request ports while IDLE.
   assign acc     = (state == IDLE) ? req_t'{req_write, req_addr, req_wdata, req_be} : lat;
   assign acc_idx = acc.addr[AW+1:2];

`ifdef DMEM_ERR_EN
   assign acc_err = (|acc.addr[1:0]) || (|acc.addr[31:AW+2]);
`else
   // Upper address bits wrap and byte offset is ignored in this build.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{acc.addr[31:AW+2], acc.addr[1:0]};
   assign acc_err = 1'b0;
`endif

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   // Next-state, wait-counter and access-strobe logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      do_access = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  do_access = 1'b1;
                  state_nxt = RESP;
               end else begin
                  cnt_nxt   = 4'(WAIT_CYCLES);
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               do_access = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and wait counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Capture the request on accept; only read back while waiting.
   always_ff @(posedge clk) begin
      if (accept) lat <= acc;
   end

   // Response payload: loaded on the access edge, held through RESP and IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (do_access) begin
         rsp_err   <= acc_err;
         rsp_rdata <= (acc_err || acc.write) ? 32'd0 : mem[acc_idx];
      end
   end

   // Byte-merged store; a reset edge blocks the commit so a dropped store never lands.
   always_ff @(posedge clk) begin
      if (rst && do_access && acc.write && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc.be[i]) mem[acc_idx][8*i +: 8] <= acc.wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int WK [2] = '{2, 0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid [2];
   logic        req_write [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_ready [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic fail_now(input string name);
      total_cnt++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Each instance is either free, or busy with a transaction accepted at edge
   // acc_n; the memory effect happens at edge acc_n+W and the response is then
   // presented until an edge with rsp_ready. Per-byte "known" flags let loads of
   // never-written bytes go unchecked.
   bit          mvalid = 0;
   longint      n = 0;
   bit          busy [2];
   bit          resp [2];
   longint      acc_n [2];
   logic        mw  [2];
   logic [31:0] ma  [2];
   logic [31:0] mwd [2];
   logic [3:0]  mbe [2];
   logic [31:0] lrd [2];
   logic [31:0] lmask [2];
   logic        lerr [2];
   logic [31:0] mm [2][DEPTH];
   logic [3:0]  mk [2][DEPTH];

   task automatic model_access(input int k);
      int   idx;
      logic err;
      idx = int'(ma[k][9:2]);
`ifdef DMEM_ERR_EN
      err = (ma[k][1:0] != 2'b0) || (ma[k][31:10] != 22'd0);
`else
      err = 1'b0;
`endif
      resp[k]  = 1;
      lerr[k]  = err;
      lrd[k]   = 32'd0;
      lmask[k] = 32'hFFFF_FFFF;
      if (!err) begin
         if (mw[k]) begin
            for (int b = 0; b < 4; b++)
               if (mbe[k][b]) begin
                  mm[k][idx][8*b +: 8] = mwd[k][8*b +: 8];
                  mk[k][idx][b] = 1'b1;
               end
         end else begin
            lrd[k] = mm[k][idx];
            for (int b = 0; b < 4; b++) lmask[k][8*b +: 8] = {8{mk[k][idx][b]}};
         end
      end
   endtask

   always @(posedge clk) begin
      n++;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            mvalid   = 1;
            busy[k]  = 0;
            resp[k]  = 0;
            lrd[k]   = 32'd0;
            lmask[k] = 32'hFFFF_FFFF;
            lerr[k]  = 1'b0;
         end else if (mvalid) begin
            if (busy[k] && resp[k]) begin
               if (rsp_ready[k]) begin busy[k] = 0; resp[k] = 0; end
            end else if (busy[k]) begin
               if (n == acc_n[k] + longint'(WK[k])) model_access(k);
            end else if (req_valid[k]) begin
               busy[k]  = 1;
               acc_n[k] = n;
               mw[k]    = req_write[k];
               ma[k]    = req_addr[k];
               mwd[k]   = req_wdata[k];
               mbe[k]   = req_be[k];
               if (WK[k] == 0) model_access(k);
            end
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (mvalid) begin
         for (int k = 0; k < 2; k++) begin
            check1($sformatf("dut%0d.req_ready", k), req_ready[k], !busy[k]);
            check1($sformatf("dut%0d.rsp_valid", k), rsp_valid[k], busy[k] && resp[k]);
            check($sformatf("dut%0d.rsp_rdata", k), rsp_rdata[k] & lmask[k], lrd[k] & lmask[k]);
            check1($sformatf("dut%0d.rsp_err", k), rsp_err[k], lerr[k]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic txn(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input int stall, input bit pulse,
                      output logic [31:0] rd, output logic er, output int lat);
      int t;
      @(negedge clk);
      req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = addr;
      req_wdata[k] = wdata; req_be[k] = be; rsp_ready[k] = 1'b0;
      t = 0;
      while (!req_ready[k] && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) fail_now($sformatf("dut%0d accept", k));
      @(negedge clk);
      req_valid[k] = 1'b0;
      lat = 1;
      while (!rsp_valid[k] && lat < 50) begin @(negedge clk); lat++; end
      if (lat >= 50) fail_now($sformatf("dut%0d response", k));
      rd = rsp_rdata[k];
      er = rsp_err[k];
      for (int s = 0; s < stall; s++) begin
         if (pulse && s == 1) begin
            req_valid[k] = 1'b1; req_write[k] = 1'b1;
            req_addr[k] = addr; req_wdata[k] = 32'h5555_AAAA; req_be[k] = 4'hF;
         end
         @(negedge clk);
         req_valid[k] = 1'b0;
      end
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      rsp_ready[k] = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, cnt;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < DEPTH; i++) mk[k][i] = 4'b0;
         req_valid[k] = 0; req_write[k] = 0; req_addr[k] = 0;
         req_wdata[k] = 0; req_be[k] = 0; rsp_ready[k] = 0;
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check1("reset req_ready", req_ready[0], 1'b1);
      check1("reset rsp_valid", rsp_valid[0], 1'b0);
      check("reset rsp_rdata", rsp_rdata[0], 32'd0);
      check1("reset rsp_err", rsp_err[0], 1'b0);
      rst = 1'b1;

      // Prefill the low 16 words of both instances.
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++)
            txn(k, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, 0, rd, er, lat);

      // Store then load with latency check.
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat);
      check("store rdata", rd, 32'd0);
      check("store latency", 32'(lat), 32'd3);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check("load 0x10", rd, 32'hDEADBEEF);

      // Byte merge and empty byte-enable.
      txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 0, rd, er, lat);
      txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, rd, er, lat);
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check("merge 0x20", rd, 32'h11BB33DD);
      txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 0, rd, er, lat);
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check("be0 unchanged", rd, 32'h11BB33DD);

      // Backpressure with an ignored request pulse.
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1, rd, er, lat);
      check("bp load 0x10", rd, 32'hDEADBEEF);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check("bp pulse ignored", rd, 32'hDEADBEEF);

      // Reset during WAIT drops the store.
      txn(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, 0, rd, er, lat);
      @(negedge clk);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
      req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check1("midrst req_ready", req_ready[0], 1'b1);
      check1("midrst rsp_valid", rsp_valid[0], 1'b0);
      txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check("midrst load 0x30", rd, 32'hCAFEF00D);

      // Addressing per build.
      txn(0, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, 0, 0, rd, er, lat);
`ifdef DMEM_ERR_EN
      txn(0, 1'b0, 32'h402, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check1("misaligned err", er, 1'b1);
      check("misaligned rdata", rd, 32'd0);
      txn(0, 1'b1, 32'h400, 32'h5A5A1234, 4'hF, 0, 0, rd, er, lat);
      check1("oor store err", er, 1'b1);
      txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check("oor store no write", rd, 32'h0BADCAFE);
      check1("load 0x0 err", er, 1'b0);
`else
      txn(0, 1'b1, 32'h400, 32'h5A5A1234, 4'hF, 0, 0, rd, er, lat);
      txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check("alias word 0", rd, 32'h5A5A1234);
      check1("alias err", er, 1'b0);
`endif

      // Zero-wait instance: latency and back-to-back spacing.
      txn(1, 1'b1, 32'h8, 32'h01020304, 4'hF, 0, 0, rd, er, lat);
      check("w0 latency", 32'(lat), 32'd1);
      txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0, rd, er, lat);
      check("w0 load 0x8", rd, 32'h01020304);
      @(negedge clk);
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h8; rsp_ready[1] = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid[1]) cnt++;
         req_addr[1] = 32'(4 * $urandom_range(0, 15));
      end
      req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
      check("w0 b2b responses", 32'(cnt), 32'd10);

      // Randomized traffic on both instances with occasional resets.
      repeat (3000) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) != 0);
         for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'($urandom_range(0, 1));
            req_write[k] = 1'($urandom_range(0, 1));
            req_addr[k]  = {($urandom_range(0, 7) == 0) ? 22'($urandom) : 22'd0, 4'b0,
                            4'($urandom_range(0, 15)),
                            ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b0};
            req_wdata[k] = $urandom;
            req_be[k]    = 4'($urandom);
            rsp_ready[k] = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin req_valid[k] = 0; rsp_ready[k] = 1; end
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      fail_now("watchdog");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
